// File: rtl/sid_pkg.sv
// Shared definitions for the SID oscillator bank: register map, control-bit
// positions, LFSR geometry and the sequencer state encoding.
package sid_pkg;

  // Register offsets inside one voice's register window.
  localparam int REG_FREQ_LO = 0;
  localparam int REG_FREQ_HI = 1;
  localparam int REG_PW_LO   = 2;
  localparam int REG_PW_HI   = 3;
  localparam int REG_CTRL    = 4;

  // Control register bit positions (bit 0 is unused and not stored).
  localparam int CTRL_SYNC  = 1;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_NOISE = 7;

  // Noise LFSR: 23 bits, feedback from bits 22 and 17, resets to all ones.
  localparam int LFSR_W    = 23;
  localparam int LFSR_FB_A = 22;
  localparam int LFSR_FB_B = 17;
  localparam logic [LFSR_W-1:0] LFSR_RESET = '1;
  localparam int NOISE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Noise output bits, MSB first, taken from the LFSR taps.
  function automatic logic [NOISE_W-1:0] noiseTaps(input logic [LFSR_W-1:0] lfsr);
    return {lfsr[20], lfsr[18], lfsr[14], lfsr[11], lfsr[9], lfsr[5], lfsr[2], lfsr[0]};
  endfunction

  // Overwrite the LFSR tap bits with the given mixed-output bits (MSB first).
  function automatic logic [LFSR_W-1:0] noiseWriteback(input logic [LFSR_W-1:0] lfsr,
                                                       input logic [NOISE_W-1:0] bits);
    logic [LFSR_W-1:0] r;
    r     = lfsr;
    r[20] = bits[7];
    r[18] = bits[6];
    r[14] = bits[5];
    r[11] = bits[4];
    r[9]  = bits[3];
    r[5]  = bits[2];
    r[2]  = bits[1];
    r[0]  = bits[0];
    return r;
  endfunction

endpackage

// File: rtl/sid_osc_bank_if.sv
// Register write bus into the oscillator bank.
// Handshake: a write is a single cycle with iWE high; it is always accepted on
// that clock edge (there is no ready/backpressure), iAddr/iData are only
// meaningful while iWE is high.
interface sid_osc_bank_if;
  logic       iWE;
  logic [4:0] iAddr;
  logic [7:0] iData;

  modport master (output iWE, iAddr, iData);
  modport slave  (input  iWE, iAddr, iData);
endinterface

// File: rtl/sid_wave_gen.sv
// Combinational waveform generation and AND-mix for the voice currently on the
// shared datapath. Receives only the top OUT_W+1 phase bits, which cover saw,
// triangle and pulse comparison.
module sid_wave_gen
  import sid_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic [OUT_W:0]       iPhaseTop,
  input  logic [NOISE_W-1:0]   iNoise,
  input  logic [11:0]          iPw,
  input  logic [7:2]           iCtrl,
  input  logic                 iRingMsb,
  output logic [OUT_W-1:0]     oMix
);

  logic [OUT_W-1:0] sawWave;
  logic [OUT_W-1:0] triWave;
  logic [OUT_W-1:0] pulseWave;
  logic [OUT_W-1:0] noiseWave;
  logic             anySel;

  // Build each waveform, then AND together whichever are selected.
  always_comb begin
    sawWave = iPhaseTop[OUT_W -: OUT_W];
    triWave = iPhaseTop[OUT_W-1:0];
    if (iPhaseTop[OUT_W] ^ (iCtrl[CTRL_RING] & iRingMsb)) triWave = ~iPhaseTop[OUT_W-1:0];
    pulseWave = (iCtrl[CTRL_TEST] || (iPhaseTop[OUT_W -: 12] >= iPw)) ? '1 : '0;
    noiseWave = '0;
    noiseWave[OUT_W-1 -: NOISE_W] = iNoise;
    oMix   = '1;
    anySel = 1'b0;
    if (iCtrl[CTRL_TRI])   begin oMix = oMix & triWave;   anySel = 1'b1; end
    if (iCtrl[CTRL_SAW])   begin oMix = oMix & sawWave;   anySel = 1'b1; end
    if (iCtrl[CTRL_PULSE]) begin oMix = oMix & pulseWave; anySel = 1'b1; end
    if (iCtrl[CTRL_NOISE]) begin oMix = oMix & noiseWave; anySel = 1'b1; end
    if (!anySel) oMix = '0;
  end

endmodule

// File: rtl/sid_osc_bank.sv
// Time-multiplexed SID oscillator bank: one shared datapath steps through all
// voices after each clkEn tick. Sync/ring use MSBs latched at the tick, so the
// processing order does not matter.
// Optional feature macro: SID_NOISE_WRITEBACK_EN (noise LFSR tap write-back
// from the mixed output, allowing noise lockup).
module sid_osc_bank
  import sid_pkg::*;
#(
  parameter int VOICES     = 3,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 12,
  parameter int BASE_ADDR  = 0,
  parameter int REG_STRIDE = 7
) (
  input  logic                      clk,
  input  logic                      iRst,
  input  logic                      clkEn,
  sid_osc_bank_if.slave             bus,
  output logic [VOICES*OUT_W-1:0]   oVoice,
  output logic [VOICES-1:0]         oMSB,
  output logic                      oValid,
  output logic                      oBusy,
  output logic                      oOverrun,
  output logic [1:0]                oState
);

  localparam int CH_W = $clog2(VOICES);

  state_t            state, stateNext;
  logic [CH_W-1:0]   ch, src;
  logic [VOICES-1:0] msbOld, msbOld2;

  logic [15:0]       freq  [VOICES];
  logic [11:0]       pw    [VOICES];
  logic [7:1]        ctrl  [VOICES];
  logic [ACC_W-1:0]  phase [VOICES];
  logic [LFSR_W-1:0] lfsr  [VOICES];

  logic [15:0]       freqCur;
  logic [11:0]       pwCur;
  logic [7:1]        ctrlCur;
  logic [ACC_W-1:0]  phaseCur, phaseNew;
  logic [LFSR_W-1:0] lfsrCur, lfsrStep, lfsrNew;
  logic              syncHit;
  logic [OUT_W-1:0]  waveMix;
  int                addrInt;

  assign addrInt = int'(bus.iAddr);
  assign oValid  = (state == ST_DONE);
  assign oBusy   = (state != ST_IDLE);
  assign oState  = state;

  // Register file: byte writes from the bus; a step in the same cycle reads the old value.
  always_ff @(posedge clk) begin
    if (iRst) begin
      for (int v = 0; v < VOICES; v++) begin
        freq[v] <= '0;
        pw[v]   <= '0;
        ctrl[v] <= '0;
      end
    end else if (bus.iWE) begin
      for (int v = 0; v < VOICES; v++) begin
        if (addrInt == BASE_ADDR + v*REG_STRIDE + REG_FREQ_LO) freq[v][7:0]  <= bus.iData;
        if (addrInt == BASE_ADDR + v*REG_STRIDE + REG_FREQ_HI) freq[v][15:8] <= bus.iData;
        if (addrInt == BASE_ADDR + v*REG_STRIDE + REG_PW_LO)   pw[v][7:0]    <= bus.iData;
        if (addrInt == BASE_ADDR + v*REG_STRIDE + REG_PW_HI)   pw[v][11:8]   <= bus.iData[3:0];
        if (addrInt == BASE_ADDR + v*REG_STRIDE + REG_CTRL)    ctrl[v]       <= bus.iData[7:1];
      end
    end
  end

  // Sequencer state, channel counter, tick-time MSB snapshots and sticky overrun.
  always_ff @(posedge clk) begin
    if (iRst) begin
      state    <= ST_IDLE;
      ch       <= '0;
      msbOld   <= '0;
      msbOld2  <= '0;
      oOverrun <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == ST_IDLE && clkEn) begin
        msbOld  <= oMSB;
        msbOld2 <= msbOld;
        ch      <= '0;
      end else if (state == ST_RUN) begin
        ch <= ch + 1'b1;
      end
      if (clkEn && state != ST_IDLE) oOverrun <= 1'b1;
    end
  end

  // Next-state: IDLE -> RUN on tick, RUN for one cycle per voice, DONE for one cycle.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (clkEn) stateNext = ST_RUN;
      ST_RUN:  if (ch == CH_W'(VOICES-1)) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Phase and LFSR step for the voice selected by ch.
  always_comb begin
    freqCur  = freq[ch];
    pwCur    = pw[ch];
    ctrlCur  = ctrl[ch];
    phaseCur = phase[ch];
    lfsrCur  = lfsr[ch];
    src      = (ch == '0) ? CH_W'(VOICES-1) : ch - 1'b1;
    syncHit  = ctrlCur[CTRL_SYNC] && msbOld[src] && !msbOld2[src];
    if (ctrlCur[CTRL_TEST])  phaseNew = '0;
    else if (syncHit)        phaseNew = '0;
    else                     phaseNew = phaseCur + ACC_W'(freqCur);
    lfsrStep = lfsrCur;
    if (ctrlCur[CTRL_TEST])
      lfsrStep = LFSR_RESET;
    else if (!phaseCur[ACC_W-5] && phaseNew[ACC_W-5])
      lfsrStep = {lfsrCur[LFSR_W-2:0], lfsrCur[LFSR_FB_A] ^ lfsrCur[LFSR_FB_B]};
  end

  sid_wave_gen #(.OUT_W(OUT_W)) u_wave (
    .iPhaseTop (phaseNew[ACC_W-1 -: OUT_W+1]),
    .iNoise    (noiseTaps(lfsrStep)),
    .iPw       (pwCur),
    .iCtrl     (ctrlCur[7:2]),
    .iRingMsb  (msbOld[src]),
    .oMix      (waveMix)
  );

  // Optional noise write-back: mixed output bits replace the LFSR taps.
  always_comb begin
    lfsrNew = lfsrStep;
`ifdef SID_NOISE_WRITEBACK_EN
    if (ctrlCur[CTRL_NOISE] && (ctrlCur[CTRL_PULSE] || ctrlCur[CTRL_SAW] || ctrlCur[CTRL_TRI]))
      lfsrNew = noiseWriteback(lfsrStep, waveMix[OUT_W-1 -: NOISE_W]);
`endif
  end

  // Commit the processed voice: phase, LFSR, output slice and MSB.
  always_ff @(posedge clk) begin
    if (iRst) begin
      for (int v = 0; v < VOICES; v++) begin
        phase[v] <= '0;
        lfsr[v]  <= LFSR_RESET;
      end
      oVoice <= '0;
      oMSB   <= '0;
    end else if (state == ST_RUN) begin
      phase[ch]                       <= phaseNew;
      lfsr[ch]                        <= lfsrNew;
      oVoice[int'(ch)*OUT_W +: OUT_W] <= waveMix;
      oMSB[ch]                        <= phaseNew[ACC_W-1];
    end
  end

endmodule
